output_devices: RTL and testbench
=================================

# output_devices

Write-side counterpart of the CPU's memory-mapped input device mux. It accepts 32-bit writes from the core addressed by an 8-bit device address and holds each value in a per-device output register. It presents each value to its device over a valid/ready handshake, so the core is stalled instead of overwriting a value the device has not yet consumed. It sits between the core's `OUT` path and the output peripherals, in `emulator/com/`.

## Interface

Parameters:
- `NUM_DEVICES`, default 2: number of mapped output devices. Addresses 0..NUM_DEVICES-1 are mapped; the port list below is for the default.
- `WIDTH`, default 32: data width of every device register.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `address`  input  8  target device address from the core.
- `value`  input  WIDTH  write data from the core.
- `write_en`  input  1  core write request.
- `write_ready`  output  1  combinational; the write is accepted on the edge where `write_en && write_ready`.
- `device0_values`, `device1_values`  output  WIDTH  registered device data.
- `device0_valid`, `device1_valid`  output  1  data pending for the device.
- `device0_ready`, `device1_ready`  input  1  device consumes the data.
- `bad_address`  output  1  sticky flag; set by an accepted write to an unmapped address.

## Operation

- Each device channel has two states, IDLE (`valid`=0) and PENDING (`valid`=1).
- For the addressed channel, `write_ready` = `!deviceN_valid || deviceN_ready`.
- For an unmapped address (address >= NUM_DEVICES), `write_ready` = 1. The write is accepted and its data is dropped. `bad_address` is set to 1 on that edge and stays set until reset.
- Accepted write to channel N:
  - `deviceN_values` <= `value`.
  - Channel N goes to PENDING.
- Device handshake on channel N, where `valid && ready` at an edge:
  - The channel returns to IDLE, unless a write to N is accepted on the same edge.
  - If a write to N is accepted on the same edge, the new data is loaded and `valid` stays 1.
- `ready` while IDLE has no effect.
- `deviceN_values` holds its last value after the ack. It changes only on an accepted write to N.
- Writes to one channel never affect another channel's value or valid.
- `write_en` with `write_ready`=0 has no state effect; the core holds the request.

## Timing

- Reset, asynchronous and immediate: all `deviceN_values` = 0, all `deviceN_valid` = 0, `bad_address` = 0.
- With `reset_n` low and `write_en` low, `write_ready` reads 1.
- Reset asserted mid-handshake discards pending data; no ack is required afterward.
- Write latency: value and valid are visible one cycle after the accepting edge.
- Back-to-back writes to the same channel:
  - The second write is accepted only on a cycle where that device asserts `ready`.
  - Sustained throughput is one write per cycle if `ready` is held high.
- Alternating writes to different idle channels are accepted every cycle.
- Full 8-bit address compare; no aliasing. For example, address 8'h80 is unmapped.

## Configuration

- `OUTPUT_DEVICES_READBACK_EN` defined:
  - Adds output `read_value` (WIDTH), a combinational mux of `deviceN_values[address]`.
  - `read_value` = 0 for unmapped addresses.
  - Lets the core read back what it last wrote.
- Undefined: the port does not exist, and no readback mux is built.

## Test plan

- Reset, then address=0, value=32'hE5F84AB1, write_en for 1 cycle:
  - Next cycle `device0_values`=32'hE5F84AB1, `device0_valid`=1.
  - `device1_valid`=0.
  - Then `device0_ready`=1 for 1 cycle, and `device0_valid`=0 the following cycle while the value holds.
- Channel 0 PENDING with `device0_ready`=0, then write 32'h5C8C6A01 to address 0:
  - `write_ready`=0, and the value is unchanged for 5 cycles.
  - Raise `ready`: the write is accepted that edge, and the value is 32'h5C8C6A01 with `valid`=1.
- Simultaneous ack and new write to address 1 with `device1_ready`=1:
  - `device1_valid` stays 1 and the new value appears.
- Write to address 8'h02 and to 8'hFF:
  - `write_ready`=1, and `bad_address`=1 thereafter.
  - Both device registers are unchanged.
  - `bad_address` clears only after `reset_n` low.
- Assert `reset_n`=0 asynchronously mid-cycle while both channels are PENDING:
  - Both valids are 0 and both values are 0 before the next clock edge.
- With `OUTPUT_DEVICES_READBACK_EN`, after writing 32'hE5F84AB1 to address 0:
  - address=0 gives `read_value`=32'hE5F84AB1.
  - address=1 gives 0.

Source files
------------

// File: rtl/output_devices.sv
// output_devices: per-device output registers handed to peripherals over valid/ready.
// Optional readback port guarded by `OUTPUT_DEVICES_READBACK_EN.
module output_devices #(
  parameter int NUM_DEVICES = 2,
  parameter int WIDTH       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       address,
  input  logic [WIDTH-1:0] value,
  input  logic             write_en,
  output logic             write_ready,
  output logic [WIDTH-1:0] device0_values,
  output logic [WIDTH-1:0] device1_values,
  output logic             device0_valid,
  output logic             device1_valid,
  input  logic             device0_ready,
  input  logic             device1_ready,
  output logic             bad_address
`ifdef OUTPUT_DEVICES_READBACK_EN
  ,
  output logic [WIDTH-1:0] read_value
`endif
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} chan_state_e;

  chan_state_e            state_q  [NUM_DEVICES];
  chan_state_e            state_d  [NUM_DEVICES];
  logic [WIDTH-1:0]       values_q [NUM_DEVICES];
  logic [WIDTH-1:0]       values_d [NUM_DEVICES];
  logic                   bad_q, bad_d;
  logic [NUM_DEVICES-1:0] sel;
  logic [NUM_DEVICES-1:0] ready_v;
  logic                   mapped;
  logic                   accept;

  // Full 8-bit compare per channel, so no upper-bit aliasing.
  always_comb begin
    sel     = '0;
    ready_v = '0;
    ready_v[0] = device0_ready;
    ready_v[1] = device1_ready;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      sel[i] = (address == 8'(i));
    end
    mapped = |sel;
  end

  always_comb begin
    write_ready = 1'b1;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (sel[i]) write_ready = (state_q[i] == IDLE) || ready_v[i];
    end
  end

  assign accept = write_en && write_ready;

  // An accepted write overrides a same-edge ack, keeping the channel pending.
  always_comb begin
    for (int i = 0; i < NUM_DEVICES; i++) begin
      state_d[i]  = state_q[i];
      values_d[i] = values_q[i];
      if (state_q[i] == PENDING && ready_v[i]) state_d[i] = IDLE;
      if (accept && sel[i]) begin
        state_d[i]  = PENDING;
        values_d[i] = value;
      end
    end
    bad_d = bad_q || (accept && !mapped);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DEVICES; i++) begin
        state_q[i]  <= IDLE;
        values_q[i] <= '0;
      end
      bad_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DEVICES; i++) begin
        state_q[i]  <= state_d[i];
        values_q[i] <= values_d[i];
      end
      bad_q <= bad_d;
    end
  end

  assign device0_values = values_q[0];
  assign device1_values = values_q[1];
  assign device0_valid  = (state_q[0] == PENDING);
  assign device1_valid  = (state_q[1] == PENDING);
  assign bad_address    = bad_q;

`ifdef OUTPUT_DEVICES_READBACK_EN
  always_comb begin
    read_value = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (sel[i]) read_value = values_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_output_devices.sv
// Self-checking bench for output_devices against a behavioural channel model.
// Define OUTPUT_DEVICES_READBACK_EN to also exercise the readback port.
module tb_output_devices;

  logic        clk;
  logic        reset_n;
  logic [7:0]  address;
  logic [31:0] value;
  logic        write_en;
  logic        write_ready;
  logic [31:0] device0_values, device1_values;
  logic        device0_valid, device1_valid;
  logic        device0_ready, device1_ready;
  logic        bad_address;
`ifdef OUTPUT_DEVICES_READBACK_EN
  logic [31:0] read_value;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what each device holds, whether it is owed a handoff.
  logic [31:0] mval [2];
  logic        mvld [2];
  logic        mbad;

  output_devices #(.NUM_DEVICES(2), .WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address        (address),
    .value          (value),
    .write_en       (write_en),
    .write_ready    (write_ready),
    .device0_values (device0_values),
    .device1_values (device1_values),
    .device0_valid  (device0_valid),
    .device1_valid  (device1_valid),
    .device0_ready  (device0_ready),
    .device1_ready  (device1_ready),
    .bad_address    (bad_address)
`ifdef OUTPUT_DEVICES_READBACK_EN
    ,
    .read_value     (read_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic dev_ready(input int i);
    return (i == 0) ? device0_ready : device1_ready;
  endfunction

  function automatic logic model_write_ready(input logic [7:0] a);
    if (a < 8'd2) return !mvld[a] || dev_ready(int'(a));
    return 1'b1;
  endfunction

  task automatic model_clear();
    mval[0] = '0; mval[1] = '0; mvld[0] = 0; mvld[1] = 0; mbad = 0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic cycle();
    logic        acc;
    logic [31:0] nval [2];
    logic        nvld [2];
    logic        nbad;
    acc  = write_en && model_write_ready(address);
    nbad = mbad;
    for (int i = 0; i < 2; i++) begin
      nval[i] = mval[i];
      nvld[i] = mvld[i] && !dev_ready(i);
    end
    if (acc) begin
      if (address < 8'd2) begin
        nval[address] = value;
        nvld[address] = 1'b1;
      end else begin
        nbad = 1'b1;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      mval[i] = nval[i];
      mvld[i] = nvld[i];
    end
    mbad = nbad;
    #1;
  endtask

  task automatic drain();
    write_en = 0; device0_ready = 1; device1_ready = 1;
    cycle();
    device0_ready = 0; device1_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; write_en = 0; address = 0; value = 0;
    device0_ready = 0; device1_ready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL reset_write_ready got %0b want 1", write_ready); end
    n_checks++;
    if ({device0_valid, device1_valid, bad_address} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b want 000", {device0_valid, device1_valid, bad_address});
    end
    n_checks++;
    if (device0_values !== 32'h0 || device1_values !== 32'h0) begin
      n_fail++; $display("FAIL reset_values got %h/%h want 0/0", device0_values, device1_values);
    end
    reset_n = 1;
  endtask

  task automatic test_basic();
    address = 8'd0; value = 32'hE5F84AB1; write_en = 1;
    #1;
    n_checks++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL basic_write_ready got %0b want 1", write_ready); end
    cycle();
    write_en = 0;
    n_checks++;
    if (device0_values !== 32'hE5F84AB1 || device0_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_load got %h v%0b want e5f84ab1 v1", device0_values, device0_valid);
    end
    n_checks++;
    if (device1_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dev1_valid got %0b want 0", device1_valid); end
    device0_ready = 1;
    cycle();
    device0_ready = 0;
    n_checks++;
    if (device0_valid !== 1'b0 || device0_values !== 32'hE5F84AB1) begin
      n_fail++; $display("FAIL basic_ack got %h v%0b want e5f84ab1 v0", device0_values, device0_valid);
    end
  endtask

  task automatic test_stall();
    address = 8'd0; value = 32'h1111_2222; write_en = 1;
    cycle();
    value = 32'h5C8C6A01; device0_ready = 0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (write_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %0b want 0", k, write_ready); end
      cycle();
      n_checks++;
      if (device0_values !== 32'h1111_2222 || device0_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got %h v%0b want 11112222 v1", k, device0_values, device0_valid);
      end
    end
    device0_ready = 1;
    #1;
    n_checks++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %0b want 1", write_ready); end
    cycle();
    write_en = 0; device0_ready = 0;
    n_checks++;
    if (device0_values !== 32'h5C8C6A01 || device0_valid !== 1'b1) begin
      n_fail++; $display("FAIL stall_accept got %h v%0b want 5c8c6a01 v1", device0_values, device0_valid);
    end
    drain();
  endtask

  task automatic test_simul_ack();
    address = 8'd1; value = 32'hA5A5_0001; write_en = 1;
    cycle();
    value = 32'h0BAD_F00D; device1_ready = 1;
    #1;
    n_checks++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready got %0b want 1", write_ready); end
    cycle();
    write_en = 0; device1_ready = 0;
    n_checks++;
    if (device1_values !== 32'h0BAD_F00D || device1_valid !== 1'b1) begin
      n_fail++; $display("FAIL simul_reload got %h v%0b want 0badf00d v1", device1_values, device1_valid);
    end
    n_checks++;
    if (device0_valid !== mvld[0] || device0_values !== mval[0]) begin
      n_fail++; $display("FAIL simul_isolation got %h v%0b want %h v%0b", device0_values, device0_valid, mval[0], mvld[0]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    address = 8'd0; write_en = 1; device0_ready = 1;
    for (int k = 0; k < 8; k++) begin
      v = $urandom; value = v;
      #1;
      n_checks++;
      if (write_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0b want 1", k, write_ready); end
      cycle();
      n_checks++;
      if (device0_values !== v || device0_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_data[%0d] got %h v%0b want %h v1", k, device0_values, device0_valid, v);
      end
    end
    drain();
    write_en = 1;
    for (int k = 0; k < 2; k++) begin
      address = 8'(k); value = 32'hC0DE_0000 + 32'(k);
      #1;
      n_checks++;
      if (write_ready !== 1'b1) begin n_fail++; $display("FAIL alt_ready[%0d] got %0b want 1", k, write_ready); end
      cycle();
    end
    write_en = 0;
    n_checks++;
    if (device0_values !== 32'hC0DE_0000 || device1_values !== 32'hC0DE_0001 || !device0_valid || !device1_valid) begin
      n_fail++; $display("FAIL alt_data got %h/%h v%0b%0b want c0de0000/c0de0001 v11",
                         device0_values, device1_values, device0_valid, device1_valid);
    end
  endtask

  task automatic test_bad_address();
    logic [7:0] bad_list [3];
    bad_list[0] = 8'h02; bad_list[1] = 8'hFF; bad_list[2] = 8'h80;
    for (int k = 0; k < 3; k++) begin
      address = bad_list[k]; value = $urandom; write_en = 1;
      #1;
      n_checks++;
      if (write_ready !== 1'b1) begin n_fail++; $display("FAIL bad_ready[%h] got %0b want 1", address, write_ready); end
      cycle();
      write_en = 0;
      n_checks++;
      if (bad_address !== 1'b1) begin n_fail++; $display("FAIL bad_flag[%h] got %0b want 1", address, bad_address); end
      n_checks++;
      if (device0_values !== 32'hC0DE_0000 || device1_values !== 32'hC0DE_0001 || !device0_valid || !device1_valid) begin
        n_fail++; $display("FAIL bad_untouched[%h] got %h/%h v%0b%0b", address, device0_values, device1_values,
                           device0_valid, device1_valid);
      end
    end
    cycle();
    n_checks++;
    if (bad_address !== 1'b1) begin n_fail++; $display("FAIL bad_sticky got %0b want 1", bad_address); end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 5))
        0, 1:    address = 8'd0;
        2, 3:    address = 8'd1;
        4:       address = 8'h80;
        default: address = 8'($urandom);
      endcase
      value = $urandom; write_en = 1'($urandom);
      device0_ready = 1'($urandom); device1_ready = 1'($urandom);
      #1;
      n_checks++;
      if (write_ready !== model_write_ready(address)) begin
        n_fail++; $display("FAIL rand_ready[%0d] got %0b want %0b", k, write_ready, model_write_ready(address));
      end
      cycle();
      n_checks++;
      if (device0_values !== mval[0] || device0_valid !== mvld[0]) begin
        n_fail++; $display("FAIL rand_dev0[%0d] got %h v%0b want %h v%0b", k, device0_values, device0_valid, mval[0], mvld[0]);
      end
      n_checks++;
      if (device1_values !== mval[1] || device1_valid !== mvld[1]) begin
        n_fail++; $display("FAIL rand_dev1[%0d] got %h v%0b want %h v%0b", k, device1_values, device1_valid, mval[1], mvld[1]);
      end
      n_checks++;
      if (bad_address !== mbad) begin n_fail++; $display("FAIL rand_bad[%0d] got %0b want %0b", k, bad_address, mbad); end
    end
    write_en = 0; device0_ready = 0; device1_ready = 0;
  endtask

  task automatic test_async_reset();
    write_en = 1; device0_ready = 0; device1_ready = 0;
    address = 8'd0; value = 32'h1234_5678; cycle();
    address = 8'd1; value = 32'h9ABC_DEF0; cycle();
    address = 8'hFF; cycle();
    write_en = 0;
    n_checks++;
    if (!device0_valid || !device1_valid || !bad_address) begin
      n_fail++; $display("FAIL areset_setup got v%0b%0b bad%0b want v11 bad1", device0_valid, device1_valid, bad_address);
    end
    #2;
    reset_n = 0;
    #1;
    model_clear();
    n_checks++;
    if ({device0_valid, device1_valid, bad_address} !== 3'b000) begin
      n_fail++; $display("FAIL areset_flags got %b want 000", {device0_valid, device1_valid, bad_address});
    end
    n_checks++;
    if (device0_values !== 32'h0 || device1_values !== 32'h0) begin
      n_fail++; $display("FAIL areset_values got %h/%h want 0/0", device0_values, device1_values);
    end
    address = 8'd0;
    #1;
    n_checks++;
    if (write_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready got %0b want 1", write_ready); end
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

`ifdef OUTPUT_DEVICES_READBACK_EN
  task automatic test_readback();
    logic [7:0] addrs [3];
    logic [31:0] exp;
    address = 8'd0; value = 32'hE5F84AB1; write_en = 1;
    cycle();
    write_en = 0;
    addrs[0] = 8'd0; addrs[1] = 8'd1; addrs[2] = 8'h80;
    for (int k = 0; k < 3; k++) begin
      address = addrs[k];
      #1;
      exp = (address < 8'd2) ? mval[address] : 32'h0;
      n_checks++;
      if (read_value !== exp) begin n_fail++; $display("FAIL readback[%h] got %h want %h", address, read_value, exp); end
    end
    n_checks++;
    if (mval[0] !== 32'hE5F84AB1 || mval[1] !== 32'h0) begin
      n_fail++; $display("FAIL readback_model got %h/%h want e5f84ab1/0", mval[0], mval[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_simul_ack();
    test_back_to_back();
    test_bad_address();
    test_random();
    test_async_reset();
`ifdef OUTPUT_DEVICES_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
